// File: rtl/dac_start_sequencer_pkg.sv
// Shared types for the DAC start sequencer: state codes, ctrl bit indices, status layout.
// Pure declarations; no latency. No backpressure.
// Status packing lives here so software-facing bit positions are defined once.
package dac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SYNC      = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_t;

  localparam int START_BIT = 0;
  localparam int STOP_BIT  = 1;

  localparam int STAT_STATE_LSB     = 0;
  localparam int STAT_ERR_TIMEOUT   = 3;
  localparam int STAT_ERR_LOCKLOSS  = 4;
  localparam int STAT_START_CNT_LSB = 8;
  localparam int STAT_LOCK_WAIT_LSB = 16;

  function automatic logic [31:0] pack_status(input seq_state_t st,
                                              input logic err_timeout,
                                              input logic err_lockloss,
                                              input logic [7:0] start_cnt,
                                              input logic [15:0] lock_wait);
    logic [31:0] w;
    w = '0;
    w[STAT_STATE_LSB +: 3]      = st;
    w[STAT_ERR_TIMEOUT]         = err_timeout;
    w[STAT_ERR_LOCKLOSS]        = err_lockloss;
    w[STAT_START_CNT_LSB +: 8]  = start_cnt;
    w[STAT_LOCK_WAIT_LSB +: 16] = lock_wait;
    return w;
  endfunction

endpackage

// File: rtl/dac_start_sequencer_if.sv
// Control/status bundle between the software register side and the DAC sequencer.
// Wires only; no latency. No backpressure: ctrl_word is a level, status is always valid.
// master = register/board side, slave = sequencer.
interface dac_start_sequencer_if;
  logic [31:0] ctrl_word;
  logic        dac_locked;
  logic        dac_rst;
  logic        dac_sync;
  logic        dac_run;
  logic        busy;
  logic [31:0] status;

  modport master (
    output ctrl_word, dac_locked,
    input  dac_rst, dac_sync, dac_run, busy, status
  );

  modport slave (
    input  ctrl_word, dac_locked,
    output dac_rst, dac_sync, dac_run, busy, status
  );
endinterface

// File: rtl/dac_start_sequencer_sync_2ff.sv
// Generic two-flop single-bit synchroniser with asynchronous active-high reset.
// Latency: 2 clk cycles. No backpressure.
// Only for level signals; pulses shorter than a clock period may be lost.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dac_start_sequencer.sv
// Turns the startDAC control word into a timed DAC bring-up: reset, wait-for-lock, sync, run.
// Latency: start edge sampled at edge n -> dac_rst from cycle n+1; lock seen 2 cycles late.
// No backpressure: ctrl_word is sampled every cycle, stop overrides everything.
module dac_start_sequencer
  import dac_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int SYNC_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  dac_start_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  seq_state_t       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt, cnt_inc;
  logic             err_timeout, nxt_err_timeout;
  logic             err_lockloss, nxt_err_lockloss;
  logic [7:0]       start_cnt, nxt_start_cnt;
  logic [15:0]      lock_wait, nxt_lock_wait;
  logic             start_prev, start_rise, stop, lock_s;
  logic             ctrl_unused;

  sync_2ff u_lock_sync (
    .clk (user_clk),
    .rst (user_rst),
    .d   (bus.dac_locked),
    .q   (lock_s)
  );

  assign start_rise  = bus.ctrl_word[START_BIT] & ~start_prev;
  assign stop        = bus.ctrl_word[STOP_BIT];
  assign ctrl_unused = ^bus.ctrl_word[31:STOP_BIT+1];
  assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    nxt_state        = state;
    nxt_cnt          = cnt;
    nxt_err_timeout  = err_timeout;
    nxt_err_lockloss = err_lockloss;
    nxt_start_cnt    = start_cnt;
    nxt_lock_wait    = lock_wait;
    if (stop) begin
      nxt_state        = ST_IDLE;
      nxt_cnt          = '0;
      nxt_err_timeout  = 1'b0;
      nxt_err_lockloss = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            nxt_state     = ST_RESET;
            nxt_cnt       = '0;
            nxt_start_cnt = start_cnt + 8'd1;
          end
        end
        ST_RESET: begin
          if (cnt == RST_LAST) begin
            nxt_state = ST_WAIT_LOCK;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so a lock arriving on the last allowed cycle still wins.
          if (lock_s) begin
            nxt_state     = ST_SYNC;
            nxt_cnt       = '0;
            nxt_lock_wait = 16'(cnt);
          end else if (cnt == TO_LAST) begin
            nxt_state       = ST_FAULT;
            nxt_cnt         = '0;
            nxt_err_timeout = 1'b1;
          end else begin
            nxt_cnt = cnt_inc;
          end
        end
        ST_SYNC: begin
          if (cnt == SYNC_LAST) begin
            nxt_state = ST_RUN;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt_inc;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            nxt_state        = ST_FAULT;
            nxt_err_lockloss = 1'b1;
          end
        end
        ST_FAULT: begin
          if (start_rise) begin
            nxt_state        = ST_RESET;
            nxt_cnt          = '0;
            nxt_err_timeout  = 1'b0;
            nxt_err_lockloss = 1'b0;
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs and status are registered from the next state so they line up with the state register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      err_timeout  <= 1'b0;
      err_lockloss <= 1'b0;
      start_cnt    <= 8'd0;
      lock_wait    <= 16'd0;
      start_prev   <= 1'b0;
      bus.dac_rst  <= 1'b0;
      bus.dac_sync <= 1'b0;
      bus.dac_run  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.status   <= 32'd0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      err_timeout  <= nxt_err_timeout;
      err_lockloss <= nxt_err_lockloss;
      start_cnt    <= nxt_start_cnt;
      lock_wait    <= nxt_lock_wait;
      start_prev   <= bus.ctrl_word[START_BIT];
      bus.dac_rst  <= (nxt_state == ST_RESET);
      bus.dac_sync <= (nxt_state == ST_SYNC);
      bus.dac_run  <= (nxt_state == ST_RUN);
      bus.busy     <= (nxt_state == ST_RESET) || (nxt_state == ST_WAIT_LOCK) ||
                      (nxt_state == ST_SYNC);
      bus.status   <= pack_status(nxt_state, nxt_err_timeout, nxt_err_lockloss,
                                  nxt_start_cnt, nxt_lock_wait);
    end
  end

endmodule

// File: tb/tb_dac_start_sequencer.sv
// Self-checking bench for dac_start_sequencer against an event-level model of the bring-up rules.
module tb_dac_start_sequencer;

  localparam int RST_CYC  = 16;
  localparam int SYNC_CYC = 4;
  localparam int TO       = 64;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_RESET = 3'd1;
  localparam logic [2:0] C_WAIT  = 3'd2;
  localparam logic [2:0] C_SYNC  = 3'd3;
  localparam logic [2:0] C_RUN   = 3'd4;
  localparam logic [2:0] C_FAULT = 3'd5;

  logic user_clk = 1'b0;
  logic user_rst;

  dac_start_sequencer_if bus ();

  dac_start_sequencer #(
    .RST_CYCLES  (RST_CYC),
    .SYNC_CYCLES (SYNC_CYC),
    .LOCK_TIMEOUT(TO),
    .CNT_W       (16)
  ) dut (
    .user_clk(user_clk),
    .user_rst(user_rst),
    .bus     (bus)
  );

  always #5 user_clk = ~user_clk;

  int errors = 0;
  int checks = 0;
  int exp_start_cnt = 0;
  logic [15:0] exp_lock_wait = 16'd0;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_rst_fall(output int hi);
    hi = 0;
    while (bus.dac_rst === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    checks++;
    if (bus.dac_rst !== 1'b0) begin
      errors++;
      $display("FAIL rst_fall_bound: dac_rst=%b after %0d cycles, required 0", bus.dac_rst, hi);
    end
  endtask

  task automatic wait_code(input logic [2:0] code, output int n);
    n = 0;
    while (bus.status[2:0] !== code && n < 300) begin
      n++;
      tick();
    end
    checks++;
    if (bus.status[2:0] !== code) begin
      errors++;
      $display("FAIL state_bound: state=%0d after %0d cycles, required %0d", bus.status[2:0], n, code);
    end
  endtask

  task automatic stop_to_idle();
    bus.ctrl_word = 32'd2;
    tick();
    bus.ctrl_word = 32'd0;
    tick();
  endtask

  // Valid only from IDLE: a fresh start edge always bumps the start counter there.
  task automatic launch();
    bus.ctrl_word = 32'd0;
    tick();
    bus.ctrl_word = 32'd1;
    tick();
    exp_start_cnt = (exp_start_cnt + 1) % 256;
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    bus.ctrl_word = 32'd0;
    bus.dac_locked = 1'b0;
    repeat (3) tick();
    checks++; if (bus.dac_rst !== 1'b0) begin errors++; $display("FAIL reset_dac_rst: got %b want 0", bus.dac_rst); end
    checks++; if (bus.dac_sync !== 1'b0) begin errors++; $display("FAIL reset_dac_sync: got %b want 0", bus.dac_sync); end
    checks++; if (bus.dac_run !== 1'b0) begin errors++; $display("FAIL reset_dac_run: got %b want 0", bus.dac_run); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.status !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", bus.status); end
    user_rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.status !== 32'd0) begin errors++; $display("FAIL idle_status: got %h want 0", bus.status); end
    exp_start_cnt = 0;
    exp_lock_wait = 16'd0;
  endtask

  task automatic test_nominal();
    int hi, n, s;
    launch();
    checks++; if (bus.status[2:0] !== C_RESET) begin errors++; $display("FAIL nom_start_latency: state=%0d want %0d", bus.status[2:0], C_RESET); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nom_busy_reset: got %b want 1", bus.busy); end
    wait_rst_fall(hi);
    checks++; if (hi != RST_CYC) begin errors++; $display("FAIL nom_rst_width: got %0d want %0d", hi, RST_CYC); end
    checks++; if (bus.status[2:0] !== C_WAIT) begin errors++; $display("FAIL nom_wait_entry: state=%0d want %0d", bus.status[2:0], C_WAIT); end
    repeat (10) tick();
    bus.dac_locked = 1'b1;
    exp_lock_wait = 16'd12;
    wait_code(C_SYNC, n);
    s = 0;
    while (bus.dac_sync === 1'b1 && s < 50) begin
      s++;
      tick();
    end
    checks++; if (s != SYNC_CYC) begin errors++; $display("FAIL nom_sync_width: got %0d want %0d", s, SYNC_CYC); end
    checks++; if (bus.dac_run !== 1'b1) begin errors++; $display("FAIL nom_run: got %b want 1", bus.dac_run); end
    checks++; if (bus.status[2:0] !== C_RUN) begin errors++; $display("FAIL nom_state_run: got %0d want %0d", bus.status[2:0], C_RUN); end
    checks++; if (bus.status[15:8] !== 8'(exp_start_cnt)) begin errors++; $display("FAIL nom_start_cnt: got %0d want %0d", bus.status[15:8], exp_start_cnt); end
    checks++; if (bus.status[31:16] !== exp_lock_wait) begin errors++; $display("FAIL nom_lock_wait: got %0d want %0d", bus.status[31:16], exp_lock_wait); end
    checks++; if (bus.status[7:3] !== 5'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL nom_flags: status[7:3]=%b busy=%b want 0/0", bus.status[7:3], bus.busy); end
  endtask

  task automatic test_lock_loss();
    bus.dac_locked = 1'b0;
    tick();
    tick();
    checks++; if (bus.dac_run !== 1'b1) begin errors++; $display("FAIL ll_run_early: got %b want 1", bus.dac_run); end
    tick();
    checks++; if (bus.dac_run !== 1'b0) begin errors++; $display("FAIL ll_run_fall: got %b want 0", bus.dac_run); end
    checks++; if (bus.status[2:0] !== C_FAULT) begin errors++; $display("FAIL ll_state: got %0d want %0d", bus.status[2:0], C_FAULT); end
    checks++; if (bus.status[4:3] !== 2'b10) begin errors++; $display("FAIL ll_err_bits: got %b want 10", bus.status[4:3]); end
    checks++; if (bus.dac_rst !== 1'b0 || bus.dac_sync !== 1'b0) begin errors++; $display("FAIL ll_outputs: rst=%b sync=%b want 0/0", bus.dac_rst, bus.dac_sync); end
  endtask

  task automatic test_stop_priority();
    int hi;
    stop_to_idle();
    checks++; if (bus.status[4:0] !== 5'd0) begin errors++; $display("FAIL stop_clears_fault: status[4:0]=%b want 0", bus.status[4:0]); end
    launch();
    wait_rst_fall(hi);
    checks++; if (bus.status[2:0] !== C_WAIT) begin errors++; $display("FAIL sp_wait: state=%0d want %0d", bus.status[2:0], C_WAIT); end
    bus.ctrl_word = 32'd0;
    tick();
    bus.ctrl_word = 32'd3;
    tick();
    checks++; if (bus.status[2:0] !== C_IDLE) begin errors++; $display("FAIL sp_idle: state=%0d want %0d", bus.status[2:0], C_IDLE); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sp_busy: got %b want 0", bus.busy); end
    bus.ctrl_word = 32'd1;
    repeat (3) tick();
    checks++; if (bus.status[2:0] !== C_IDLE) begin errors++; $display("FAIL sp_no_retrigger: state=%0d want %0d", bus.status[2:0], C_IDLE); end
    checks++; if (bus.status[15:8] !== 8'(exp_start_cnt)) begin errors++; $display("FAIL sp_start_cnt: got %0d want %0d", bus.status[15:8], exp_start_cnt); end
  endtask

  task automatic test_retrigger();
    int hi, n;
    launch();
    wait_rst_fall(hi);
    bus.dac_locked = 1'b1;
    exp_lock_wait = 16'd2;
    wait_code(C_SYNC, n);
    bus.ctrl_word = 32'd0;
    tick();
    bus.ctrl_word = 32'd1;
    tick();
    checks++; if (bus.status[2:0] !== C_SYNC) begin errors++; $display("FAIL rt_still_sync: state=%0d want %0d", bus.status[2:0], C_SYNC); end
    checks++; if (bus.status[15:8] !== 8'(exp_start_cnt)) begin errors++; $display("FAIL rt_start_cnt: got %0d want %0d", bus.status[15:8], exp_start_cnt); end
    wait_code(C_RUN, n);
    checks++; if (bus.status[31:16] !== exp_lock_wait) begin errors++; $display("FAIL rt_lock_wait: got %0d want %0d", bus.status[31:16], exp_lock_wait); end
  endtask

  task automatic test_random_lock();
    int hi, n, d;
    logic [2:0] exp_code;
    logic exp_to;
    for (int it = 0; it < 10; it++) begin
      if (it == 0) d = TO - 3;
      else if (it == 1) d = TO - 2;
      else d = $urandom_range(0, TO + 6);
      stop_to_idle();
      bus.dac_locked = 1'b0;
      launch();
      wait_rst_fall(hi);
      repeat (d) tick();
      bus.dac_locked = 1'b1;
      n = 0;
      while (bus.status[2:0] !== C_RUN && bus.status[2:0] !== C_FAULT && n < 200) begin
        n++;
        tick();
      end
      // The synchroniser adds two cycles; the last legal WAIT_LOCK count is TO-1.
      if (d + 2 <= TO - 1) begin
        exp_code = C_RUN;
        exp_to = 1'b0;
        exp_lock_wait = 16'(d + 2);
      end else begin
        exp_code = C_FAULT;
        exp_to = 1'b1;
      end
      checks++; if (bus.status[2:0] !== exp_code) begin errors++; $display("FAIL rl_state d=%0d: got %0d want %0d", d, bus.status[2:0], exp_code); end
      checks++; if (bus.status[3] !== exp_to) begin errors++; $display("FAIL rl_timeout d=%0d: got %b want %b", d, bus.status[3], exp_to); end
      checks++; if (bus.status[31:16] !== exp_lock_wait) begin errors++; $display("FAIL rl_lock_wait d=%0d: got %0d want %0d", d, bus.status[31:16], exp_lock_wait); end
      checks++; if (bus.status[15:8] !== 8'(exp_start_cnt)) begin errors++; $display("FAIL rl_start_cnt d=%0d: got %0d want %0d", d, bus.status[15:8], exp_start_cnt); end
    end
  endtask

  task automatic test_wrap();
    int k;
    stop_to_idle();
    k = 256 - exp_start_cnt;
    for (int i = 0; i < k; i++) begin
      bus.ctrl_word = 32'd1;
      tick();
      bus.ctrl_word = 32'd2;
      tick();
      exp_start_cnt = (exp_start_cnt + 1) % 256;
      if (exp_start_cnt == 255) begin
        checks++; if (bus.status[15:8] !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", bus.status[15:8]); end
      end
    end
    checks++; if (bus.status[15:8] !== 8'(exp_start_cnt)) begin errors++; $display("FAIL wrap_zero: got %0d want %0d", bus.status[15:8], exp_start_cnt); end
    bus.ctrl_word = 32'd0;
    tick();
  endtask

  task automatic test_timeout();
    int hi, n;
    logic run_seen;
    stop_to_idle();
    bus.dac_locked = 1'b0;
    launch();
    wait_rst_fall(hi);
    n = 0;
    run_seen = 1'b0;
    while (bus.status[2:0] !== C_FAULT && n < 200) begin
      tick();
      n++;
      if (bus.dac_run === 1'b1) run_seen = 1'b1;
    end
    checks++; if (n != TO) begin errors++; $display("FAIL to_cycles: got %0d want %0d", n, TO); end
    checks++; if (bus.status[4:3] !== 2'b01) begin errors++; $display("FAIL to_err_bits: got %b want 01", bus.status[4:3]); end
    checks++; if (run_seen !== 1'b0) begin errors++; $display("FAIL to_run_seen: got %b want 0", run_seen); end
    bus.ctrl_word = 32'd0;
    tick();
    bus.ctrl_word = 32'd1;
    tick();
    checks++; if (bus.status[2:0] !== C_RESET) begin errors++; $display("FAIL to_restart: state=%0d want %0d", bus.status[2:0], C_RESET); end
    checks++; if (bus.status[3] !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", bus.status[3]); end
    stop_to_idle();
  endtask

  task automatic test_async_reset();
    bus.ctrl_word = 32'd0;
    tick();
    bus.ctrl_word = 32'd1;
    tick();
    tick();
    checks++; if (bus.dac_rst !== 1'b1) begin errors++; $display("FAIL ar_in_reset: got %b want 1", bus.dac_rst); end
    #2;
    user_rst = 1'b1;
    #1;
    checks++; if (bus.dac_rst !== 1'b0) begin errors++; $display("FAIL ar_dac_rst: got %b want 0", bus.dac_rst); end
    checks++; if (bus.status !== 32'd0) begin errors++; $display("FAIL ar_status: got %h want 0", bus.status); end
    bus.ctrl_word = 32'd0;
    #2;
    user_rst = 1'b0;
    exp_start_cnt = 0;
    repeat (3) tick();
    checks++; if (bus.status !== 32'd0 || bus.dac_rst !== 1'b0) begin errors++; $display("FAIL ar_no_resume: status=%h rst=%b want 0/0", bus.status, bus.dac_rst); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_stop_priority();
    test_retrigger();
    test_random_lock();
    test_wrap();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_start_sequencer.md
Name: dac_start_sequencer

Overview:
- Consumes the 32-bit software control word emitted by the startDAC OPB register in the user_clk domain.
- Converts that word into a timed DAC bring-up sequence: reset pulse, wait for lock with timeout, sync pulse, then continuous run enable.
- Produces a 32-bit status word for a simulink2ppc readback register.

Parameters:
- RST_CYCLES, 16: cycles dac_rst is held high; legal range 1..65535.
- SYNC_CYCLES, 4: cycles dac_sync is held high; legal range 1..65535.
- LOCK_TIMEOUT, 4096: maximum cycles spent in WAIT_LOCK before FAULT; legal range 1..65535.
- CNT_W, 16: width of the phase counter and of the lock-wait capture.

Ports:
- user_clk  in  1  block clock; same clock as the register's user_clk.
- user_rst  in  1  asynchronous reset, active-high.
- ctrl_word  in  32  register value. Bit0 = start (rising edge triggers). Bit1 = stop (level). Bits 31:2 ignored.
- dac_locked  in  1  DAC PLL lock, asynchronous to user_clk.
- dac_rst  out  1  DAC reset.
- dac_sync  out  1  DAC sync pulse.
- dac_run  out  1  playback enable.
- busy  out  1  high in RESET, WAIT_LOCK and SYNC.
- status  out  32  readback word.

Behaviour:
- Clocking and reset:
  - One clock, user_clk. Reset user_rst is asynchronous and active-high.
  - On reset: state=IDLE; dac_rst, dac_sync, dac_run, busy = 0; status = 0; start-edge history = 0; lock synchroniser flops = 0.
- Lock synchroniser: dac_locked passes through a 2-flop synchroniser to give lock_s. The FSM sees a change in dac_locked 2 cycles later.
- Start edge detection:
  - start_rise = ctrl_word[0] & ~start_prev. start_prev is updated every cycle, including cycles where stop is set.
  - A held-high start bit therefore never retriggers.
- Outputs are Moore-style: registered and decoded from the state register.
  - dac_rst = (state==RESET); dac_sync = (state==SYNC); dac_run = (state==RUN).
- States and transitions. Stop (ctrl_word[1]=1) has top priority from every state: next state = IDLE and counters clear.
  - IDLE: on start_rise -> RESET with cnt=0; start_cnt increments (8-bit, wraps 255->0).
  - RESET: cnt counts up. At cnt==RST_CYCLES-1 -> WAIT_LOCK with cnt=0. dac_rst is high for exactly RST_CYCLES cycles.
  - WAIT_LOCK: cnt counts up.
    - If lock_s=1 -> SYNC; lock_wait captures cnt.
    - Else if cnt==LOCK_TIMEOUT-1 -> FAULT; err_timeout set.
    - If lock_s and the timeout coincide, lock wins.
  - SYNC: dac_sync is high for exactly SYNC_CYCLES cycles, then -> RUN.
  - RUN: if lock_s falls -> FAULT and err_lockloss set.
  - FAULT: all DAC outputs are 0. Error flags are sticky.
    - start_rise -> RESET, clearing both error flags.
    - stop -> IDLE, clearing both error flags.
- start_rise while in RESET, WAIT_LOCK, SYNC or RUN is ignored (edge history still updates).
- Start latency: ctrl_word[0] first sampled 1 at clock edge n -> state=RESET from cycle n+1, dac_rst high for cycles n+1 .. n+RST_CYCLES.
- Counter: CNT_W bits, saturating. It cannot wrap within legal parameter ranges.
- Status word, registered:
  - [2:0] state code: IDLE=0, RESET=1, WAIT_LOCK=2, SYNC=3, RUN=4, FAULT=5.
  - [3] err_timeout.
  - [4] err_lockloss.
  - [7:5] 0.
  - [15:8] start_cnt.
  - [31:16] lock_wait: cycles spent in WAIT_LOCK before lock, held until the next capture.
- Reset asserted mid-sequence returns everything to reset values immediately. No sequence resumes after reset.

Decomposition:
- Shared package dac_seq_pkg holds:
  - the state enum and its 3-bit codes;
  - status bit-position constants;
  - ctrl bit indices START_BIT=0 and STOP_BIT=1.
- One sub-module: sync_2ff, a generic 2-flop bit synchroniser with asynchronous reset, used for dac_locked.

Test Plan:
- Nominal bring-up: reset, then ctrl_word=1. dac_locked rises 10 cycles after dac_rst falls (defaults).
  - Required: dac_rst high for 16 cycles; lock_wait = 12 (10 + 2 synchroniser cycles); dac_sync high for 4 cycles; then dac_run=1; status[2:0]=4; status[15:8]=1.
- Timeout: start with dac_locked held at 0 and LOCK_TIMEOUT=64.
  - Required: FAULT exactly 64 cycles after WAIT_LOCK entry; status[3]=1; dac_run never asserts.
  - Then write start 0->1: sequence restarts and status[3] clears.
- Lock loss: reach RUN, then drop dac_locked.
  - Required: dac_run falls 3 cycles later (2 synchroniser cycles + 1 state update); status[4]=1; state=5.
- Stop priority: in WAIT_LOCK, apply ctrl_word=3 with start and stop rising together.
  - Required: IDLE next cycle. Then clearing stop while start stays 1 causes no retrigger.
- Ignored retrigger and wrap: during SYNC, toggle start 1->0->1.
  - Required: no restart and start_cnt unchanged.
  - Run 256 full start/stop cycles: start_cnt wraps to 0.
- Async reset in RESET state: assert user_rst between clock edges.
  - Required: dac_rst=0 and status=0 immediately, without waiting for a clock edge.
